// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback
// over one shared memory port with variable latency, timeout and retire count.
module multicycle_ctrl #(
    parameter int W_MEM_CMD   = 2,
    parameter int MEM_TIMEOUT = 255,
    parameter int W_TO        = 8,
    parameter int W_CNT       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [W_MEM_CMD-1:0] dec_mem_cmd,
    input  logic                 dec_reg_wen,
    input  logic                 dec_exit,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_sel,
    output logic                 mem_we,
    output logic                 ir_wen,
    output logic                 mdr_wen,
    output logic                 reg_wen,
    output logic                 pc_wen,
    output logic                 halted,
    output logic                 err_timeout,
    output logic [W_CNT-1:0]     retired
);

    typedef enum logic [2:0] {
        S_RST, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    localparam logic [W_MEM_CMD-1:0] CMD_READ  = W_MEM_CMD'(1);
    localparam logic [W_MEM_CMD-1:0] CMD_WRITE = W_MEM_CMD'(2);
    localparam logic [W_TO-1:0]      TO_LAST   = W_TO'(MEM_TIMEOUT - 1);

    state_t          state;
    logic [W_TO-1:0] wait_cnt;
    logic            is_read;
    logic            is_write;
    logic            to_hit;

    assign is_read  = (dec_mem_cmd == CMD_READ);
    assign is_write = (dec_mem_cmd == CMD_WRITE);
    assign to_hit   = (wait_cnt == TO_LAST);

    // Read-data latches fire in the cycle memory completes, so they are Mealy.
    assign ir_wen  = (state == S_IF) && mem_ready;
    assign mdr_wen = (state == S_MEM) && mem_ready && is_read;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RST;
            wait_cnt    <= '0;
            mem_req     <= 1'b0;
            mem_sel     <= 1'b0;
            mem_we      <= 1'b0;
            reg_wen     <= 1'b0;
            pc_wen      <= 1'b0;
            halted      <= 1'b0;
            err_timeout <= 1'b0;
            retired     <= '0;
        end else begin
            // Registered strobes are pulses for the state being entered.
            mem_req <= 1'b0;
            mem_sel <= 1'b0;
            mem_we  <= 1'b0;
            reg_wen <= 1'b0;
            pc_wen  <= 1'b0;
            unique case (state)
                S_RST: begin
                    state    <= S_IF;
                    wait_cnt <= '0;
                    mem_req  <= 1'b1;
                end
                S_IF: begin
                    if (mem_ready) begin
                        state <= S_ID;
                    end else if (to_hit) begin
                        state       <= S_ERR;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + W_TO'(1);
                        mem_req  <= 1'b1;
                    end
                end
                S_ID: begin
                    if (dec_exit) begin
                        state   <= S_HALT;
                        halted  <= 1'b1;
                        retired <= retired + W_CNT'(1);
                    end else begin
                        state <= S_EX;
                    end
                end
                S_EX: begin
                    if (is_read || is_write) begin
                        state    <= S_MEM;
                        wait_cnt <= '0;
                        mem_req  <= 1'b1;
                        mem_sel  <= 1'b1;
                        mem_we   <= is_write;
                    end else begin
                        state   <= S_WB;
                        reg_wen <= dec_reg_wen;
                        pc_wen  <= 1'b1;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        state   <= S_WB;
                        reg_wen <= dec_reg_wen && !is_write;
                        pc_wen  <= 1'b1;
                    end else if (to_hit) begin
                        state       <= S_ERR;
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + W_TO'(1);
                        mem_req  <= 1'b1;
                        mem_sel  <= 1'b1;
                        mem_we   <= is_write;
                    end
                end
                S_WB: begin
                    state    <= S_IF;
                    wait_cnt <= '0;
                    mem_req  <= 1'b1;
                    retired  <= retired + W_CNT'(1);
                end
                S_HALT: state <= S_HALT;
                S_ERR:  state <= S_ERR;
                default: state <= S_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: random instruction mix with random stall counts
// against a schedule model of per-instruction cycle counts and strobes.
module tb_multicycle_ctrl;

    localparam int W_MEM_CMD = 2;
    localparam int TO        = 4;
    localparam int W_TO      = 3;
    localparam int W_CNT     = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [W_MEM_CMD-1:0] dec_mem_cmd = '0;
    logic                 dec_reg_wen = 1'b0;
    logic                 dec_exit = 1'b0;
    logic                 mem_ready = 1'b0;
    logic                 mem_req, mem_sel, mem_we, ir_wen, mdr_wen;
    logic                 reg_wen, pc_wen, halted, err_timeout;
    logic [W_CNT-1:0]     retired;

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    multicycle_ctrl #(
        .W_MEM_CMD(W_MEM_CMD), .MEM_TIMEOUT(TO), .W_TO(W_TO), .W_CNT(W_CNT)
    ) dut (
        .clk(clk), .rst(rst),
        .dec_mem_cmd(dec_mem_cmd), .dec_reg_wen(dec_reg_wen),
        .dec_exit(dec_exit), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we),
        .ir_wen(ir_wen), .mdr_wen(mdr_wen), .reg_wen(reg_wen),
        .pc_wen(pc_wen), .halted(halted), .err_timeout(err_timeout),
        .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {mem_req, mem_sel, mem_we, ir_wen, mdr_wen,
                reg_wen, pc_wen, halted, err_timeout};
    endfunction

    task automatic tick(input logic rdy);
        @(negedge clk);
        mem_ready = rdy;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_outs", 32'(outs()), 0);
        check("rst_retired", 32'(retired), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_low_req", 32'(mem_req), 0);
        exp_ret = 0;
    endtask

    // a = IF stalls, b = MEM stalls; the model is the cycle schedule itself.
    task automatic run_instr(input int cmd, input bit rw, input int a,
                             input int b);
        bit is_mem;
        int total;
        int n_fetch, n_data, n_we, n_bad_we, n_ir, n_mdr, n_reg, n_pc;
        int pc_at;
        logic r;
        is_mem = (cmd == 1) || (cmd == 2);
        total = 4 + a + (is_mem ? b + 1 : 0);
        n_fetch = 0; n_data = 0; n_we = 0; n_bad_we = 0;
        n_ir = 0; n_mdr = 0; n_reg = 0; n_pc = 0; pc_at = 0;
        dec_mem_cmd = W_MEM_CMD'(cmd);
        dec_reg_wen = rw;
        dec_exit = 1'b0;
        for (int k = 1; k <= total; k++) begin
            if (k <= a + 1)
                r = (k == a + 1);
            else if (is_mem && k >= a + 4 && k < total)
                r = (k == total - 1);
            else
                r = 1'($urandom_range(0, 1));
            tick(r);
            if (k == 1)
                check("retired", 32'(retired), 32'(exp_ret));
            if (mem_req && !mem_sel) n_fetch++;
            if (mem_req && mem_sel) n_data++;
            if (mem_we) n_we++;
            if (mem_we && !(mem_req && mem_sel)) n_bad_we++;
            if (ir_wen) n_ir++;
            if (mdr_wen) n_mdr++;
            if (reg_wen) n_reg++;
            if (pc_wen) begin n_pc++; pc_at = k; end
        end
        exp_ret = (exp_ret + 1) % (1 << W_CNT);
        check("fetch_cycles", n_fetch, a + 1);
        check("data_cycles", n_data, is_mem ? b + 1 : 0);
        check("we_cycles", n_we, (cmd == 2) ? b + 1 : 0);
        check("we_unqualified", n_bad_we, 0);
        check("ir_wen_count", n_ir, 1);
        check("mdr_wen_count", n_mdr, (cmd == 1) ? 1 : 0);
        check("reg_wen_count", n_reg, (rw && cmd != 2) ? 1 : 0);
        check("pc_wen_count", n_pc, 1);
        check("wb_cycle", pc_at, total);
        check("no_err", {30'd0, halted, err_timeout}, 0);
    endtask

    task automatic run_exit(input int a);
        int n_bad;
        dec_mem_cmd = W_MEM_CMD'(1);
        dec_reg_wen = 1'b1;
        dec_exit = 1'b1;
        for (int k = 1; k <= a + 2; k++)
            tick(k == a + 1);
        exp_ret = (exp_ret + 1) % (1 << W_CNT);
        n_bad = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'($urandom_range(0, 1)));
            if (mem_req || pc_wen || reg_wen || !halted) n_bad++;
        end
        check("halt_quiet", n_bad, 0);
        check("halted", 32'(halted), 1);
        check("halt_retired", 32'(retired), 32'(exp_ret));
    endtask

    task automatic run_timeout(input bit in_mem);
        int n_bad;
        dec_mem_cmd = W_MEM_CMD'(1);
        dec_reg_wen = 1'b1;
        dec_exit = 1'b0;
        if (in_mem) begin
            tick(1'b1);
            tick(1'b0);
            tick(1'b0);
        end
        n_bad = 0;
        for (int w = 1; w <= TO; w++) begin
            tick(1'b0);
            if (err_timeout || !mem_req || mem_sel != in_mem) n_bad++;
        end
        check(in_mem ? "mem_wait" : "if_wait", n_bad, 0);
        n_bad = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1'($urandom_range(0, 1)));
            if (!err_timeout || mem_req || mem_we || pc_wen || reg_wen
                || ir_wen || mdr_wen) n_bad++;
        end
        check(in_mem ? "mem_err_sticky" : "if_err_sticky", n_bad, 0);
        check("err_retired", 32'(retired), 32'(exp_ret));
    endtask

    initial begin
        do_reset();
        run_instr(0, 1'b1, 0, 0);
        run_instr(1, 1'b1, 2, 3);
        run_instr(2, 1'b1, 0, 0);
        run_instr(3, 1'b1, 3, 0);
        run_instr(1, 1'b0, 0, 3);
        for (int i = 0; i < 20; i++)
            run_instr($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));

        // abort a load in the middle of its memory phase
        dec_mem_cmd = W_MEM_CMD'(1);
        tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        tick(1'b0);
        check("mid_mem_req", {30'd0, mem_req, mem_sel}, 3);
        #2 rst = 1'b1;
        #1;
        check("async_abort", 32'(outs()), 0);
        do_reset();
        for (int i = 0; i < 5; i++)
            run_instr($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
        run_exit($urandom_range(0, TO - 1));

        do_reset();
        run_timeout(1'b0);
        do_reset();
        run_instr(0, 1'b1, 0, 0);
        run_timeout(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
